// File: rtl/snake_dir_ctrl_if.sv
// Key/collision/food pulses into the snake control stage and its registered status outputs.
// The master side is the game front end; the control stage is the slave.
interface snake_dir_ctrl_if;
    logic       Key_up;
    logic       Key_down;
    logic       Key_left;
    logic       Key_right;
    logic       Hit;
    logic       Eat;
    logic [1:0] Dir;
    logic       Step;
    logic [1:0] Game_state;
    logic [3:0] Speed_level;

    modport master (
        output Key_up, Key_down, Key_left, Key_right, Hit, Eat,
        input  Dir, Step, Game_state, Speed_level
    );

    modport slave (
        input  Key_up, Key_down, Key_left, Key_right, Hit, Eat,
        output Dir, Step, Game_state, Speed_level
    );
endinterface

// File: rtl/snake_dir_ctrl.sv
// Snake heading, move-strobe and IDLE/RUN/DEAD control; all outputs registered (1-cycle latency).
// No backpressure: key, Hit and Eat pulses are consumed in the cycle they arrive.
module snake_dir_ctrl #(
    parameter int unsigned STEP_CYCLES = 12_500_000,
    parameter int unsigned STEP_DEC    = 1_000_000,
    parameter int unsigned MAX_LEVEL   = 8
) (
    input  logic           Clk_50mhz,
    input  logic           Rst,
    snake_dir_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DEAD = 2'd2
    } state_t;

    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_DOWN  = 2'd1;
    localparam logic [1:0] DIR_LEFT  = 2'd2;
    localparam logic [1:0] DIR_RIGHT = 2'd3;

    state_t      state_q, state_d;
    logic [1:0]  dir_q, dir_d;
    logic [1:0]  pend_q, pend_d;
    logic        step_q, step_d;
    logic [3:0]  level_q, level_d;
    logic [31:0] cnt_q, cnt_d;

    logic        any_key;
    logic [1:0]  sel_dir;
    logic [31:0] period;
    logic        due;

    function automatic logic opposite(input logic [1:0] a, input logic [1:0] b);
        return (a[1] == b[1]) && (a[0] != b[0]);
    endfunction

    assign any_key = bus.Key_up | bus.Key_down | bus.Key_left | bus.Key_right;

    always_comb begin
        sel_dir = DIR_RIGHT;
        if (bus.Key_up) begin
            sel_dir = DIR_UP;
        end else if (bus.Key_down) begin
            sel_dir = DIR_DOWN;
        end else if (bus.Key_left) begin
            sel_dir = DIR_LEFT;
        end
    end

    // >= rather than == so a speed-up that shrinks the period below the count steps promptly.
    assign period = STEP_CYCLES - (32'(level_q) * STEP_DEC);
    assign due    = (cnt_q >= (period - 32'd1));

    always_ff @(posedge Clk_50mhz) begin
        if (Rst) begin
            state_q <= IDLE;
            dir_q   <= DIR_RIGHT;
            pend_q  <= DIR_RIGHT;
            step_q  <= 1'b0;
            level_q <= 4'd0;
            cnt_q   <= 32'd0;
        end else begin
            state_q <= state_d;
            dir_q   <= dir_d;
            pend_q  <= pend_d;
            step_q  <= step_d;
            level_q <= level_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        pend_d  = pend_q;
        step_d  = 1'b0;
        level_d = level_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                cnt_d = 32'd0;
                if (any_key) begin
                    state_d = RUN;
                    dir_d   = sel_dir;
                    pend_d  = sel_dir;
                end
            end

            RUN: begin
                if (bus.Hit) begin
                    state_d = DEAD;
                    cnt_d   = 32'd0;
                end else begin
                    if (due) begin
                        cnt_d  = 32'd0;
                        step_d = 1'b1;
                        dir_d  = pend_q;
                    end else begin
                        cnt_d = cnt_q + 32'd1;
                    end
                    // Reversal test is against the committed heading, so a key in the
                    // step cycle lands in pending and takes effect on the next step.
                    if (any_key && !opposite(sel_dir, dir_q)) begin
                        pend_d = sel_dir;
                    end
                    if (bus.Eat && (level_q < 4'(MAX_LEVEL))) begin
                        level_d = level_q + 4'd1;
                    end
                end
            end

            DEAD: begin
                cnt_d = 32'd0;
                if (any_key) begin
                    state_d = IDLE;
                    dir_d   = DIR_RIGHT;
                    pend_d  = DIR_RIGHT;
                    level_d = 4'd0;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = 32'd0;
            end
        endcase
    end

    assign bus.Dir         = dir_q;
    assign bus.Step        = step_q;
    assign bus.Game_state  = state_q;
    assign bus.Speed_level = level_q;

endmodule
